// File: rtl/cv32e40x_aes_rand_buffer_if.sv
// Handshake bundle between the RNG / masked SAES32 unit and the fresh-mask randomness buffer.
// The slave modport is the buffer's view; the master modport is the RNG/AES side.
interface cv32e40x_aes_rand_buffer_if #(
  parameter int DEPTH    = 4,
  parameter int SHAREB_W = 8,
  parameter int RAND_W   = 36
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic                flush_i;
  logic [31:0]         rng_word_i;
  logic                rng_valid_i;
  logic                rng_ready_o;
  logic                consume_i;
  logic [SHAREB_W-1:0] shareB_o;
  logic [RAND_W-1:0]   randombits_o;
  logic                rand_valid_o;
  logic [LEVEL_W-1:0]  level_o;
  logic                starve_o;

  modport slave (
    input  flush_i, rng_word_i, rng_valid_i, consume_i,
    output rng_ready_o, shareB_o, randombits_o, rand_valid_o, level_o, starve_o
  );

  modport master (
    output flush_i, rng_word_i, rng_valid_i, consume_i,
    input  rng_ready_o, shareB_o, randombits_o, rand_valid_o, level_o, starve_o
  );
endinterface

// File: rtl/cv32e40x_aes_rand_buffer.sv
// Packs 32-bit RNG words into 44-bit fresh-mask bundles and serves each bundle exactly once,
// first-word-fall-through, to the masked SAES32 unit.
module cv32e40x_aes_rand_buffer #(
  parameter int DEPTH    = 4,
  parameter int SHAREB_W = 8,
  parameter int RAND_W   = 36
) (
  input logic clk,
  input logic reset,
  cv32e40x_aes_rand_buffer_if.slave bus
);
  localparam int BUNDLE_W = SHAREB_W + RAND_W;
  localparam int ACC_W    = BUNDLE_W + 32;
  localparam int FILL_W   = $clog2(ACC_W + 1);
  localparam int LEVEL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(DEPTH);

  logic [ACC_W-1:0]    acc_q, acc_d, accShifted;
  logic [FILL_W-1:0]   fill_q, fill_d, fillShifted;
  logic [BUNDLE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
  logic [LEVEL_W-1:0]  level_q;
  logic                starve_q;

  logic push, pop, rngReady, transfer, headValid;
  logic [BUNDLE_W-1:0] headBundle;

  // A push only looks at the current level, so a full FIFO never pushes even if it pops this cycle.
  assign push      = (fill_q >= FILL_W'(BUNDLE_W)) && (level_q < LEVEL_W'(DEPTH));
  assign headValid = (level_q != '0);
  assign pop       = bus.consume_i && headValid;
  assign rngReady  = !bus.flush_i && ((fill_q <= FILL_W'(BUNDLE_W)) || push);
  assign transfer  = bus.rng_valid_i && rngReady;

  // The incoming word lands just above the bits left after any same-cycle shift-out.
  always_comb begin
    accShifted  = push ? (acc_q >> BUNDLE_W) : acc_q;
    fillShifted = push ? (fill_q - FILL_W'(BUNDLE_W)) : fill_q;
    acc_d       = accShifted;
    fill_d      = fillShifted;
    if (transfer) begin
      acc_d  = accShifted | (ACC_W'(bus.rng_word_i) << fillShifted);
      fill_d = fillShifted + FILL_W'(32);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      fill_q   <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.flush_i) begin
      acc_q    <= '0;
      fill_q   <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      starve_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      if (push) begin
        mem_q[wrPtr_q] <= acc_q[BUNDLE_W-1:0];
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      // Consumed entries are wiped so a spent bundle can never reappear at the head.
      if (pop) begin
        mem_q[rdPtr_q] <= '0;
        rdPtr_q        <= rdPtr_q + PTR_W'(1);
      end
      if (push && !pop)      level_q <= level_q + LEVEL_W'(1);
      else if (pop && !push) level_q <= level_q - LEVEL_W'(1);
      if (bus.consume_i && !headValid) starve_q <= 1'b1;
    end
  end

  assign headBundle       = mem_q[rdPtr_q];
  assign bus.rng_ready_o  = rngReady;
  assign bus.rand_valid_o = headValid;
  assign bus.shareB_o     = headValid ? headBundle[SHAREB_W-1:0] : '0;
  assign bus.randombits_o = headValid ? headBundle[BUNDLE_W-1:SHAREB_W] : '0;
  assign bus.level_o      = level_q;
  assign bus.starve_o     = starve_q;
endmodule

// File: tb/tb_cv32e40x_aes_rand_buffer.sv
// Directed bench for the SAES32 randomness buffer: packing, back-pressure, drain, starvation,
// flush priority and asynchronous reset, each with hand-computed expected values.
module tb_cv32e40x_aes_rand_buffer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cv32e40x_aes_rand_buffer_if bus ();

  cv32e40x_aes_rand_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset           = 1'b1;
    bus.flush_i     = 1'b0;
    bus.rng_word_i  = '0;
    bus.rng_valid_i = 1'b0;
    bus.consume_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic pushWord(input logic [31:0] w);
    bus.rng_word_i  = w;
    bus.rng_valid_i = 1'b1;
    tick();
    bus.rng_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    doReset();
    checks++; if (bus.rand_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.rand_valid_o); end
    checks++; if (bus.shareB_o !== 8'h00) begin errors++; $display("[TB] FAIL rst_shareB: got %h expected 00", bus.shareB_o); end
    checks++; if (bus.randombits_o !== 36'h0) begin errors++; $display("[TB] FAIL rst_rand: got %h expected 0", bus.randombits_o); end
    checks++; if (bus.level_o !== 3'd0) begin errors++; $display("[TB] FAIL rst_level: got %0d expected 0", bus.level_o); end
    checks++; if (bus.starve_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_starve: got %b expected 0", bus.starve_o); end
    checks++; if (bus.rng_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 1", bus.rng_ready_o); end
  endtask

  task automatic test_packing();
    $display("[TB] test_packing");
    doReset();
    pushWord(32'h03020100);
    pushWord(32'h07060504);
    tick();
    checks++; if (bus.rand_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL pack_valid: got %b expected 1", bus.rand_valid_o); end
    checks++; if (bus.shareB_o !== 8'h00) begin errors++; $display("[TB] FAIL pack_shareB: got %h expected 00", bus.shareB_o); end
    checks++; if (bus.randombits_o !== 36'h504030201) begin errors++; $display("[TB] FAIL pack_rand: got %h expected 504030201", bus.randombits_o); end
    checks++; if (bus.level_o !== 3'd1) begin errors++; $display("[TB] FAIL pack_level: got %0d expected 1", bus.level_o); end
    checks++; if (bus.rng_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL pack_ready: got %b expected 1", bus.rng_ready_o); end
    // The 20-bit residue 07060 must sit below the next word in the second bundle.
    pushWord(32'h0B0A0908);
    tick();
    bus.consume_i = 1'b1;
    tick();
    bus.consume_i = 1'b0;
    #1;
    checks++; if (bus.shareB_o !== 8'h60) begin errors++; $display("[TB] FAIL resid_shareB: got %h expected 60", bus.shareB_o); end
    checks++; if (bus.randombits_o !== 36'h0A0908070) begin errors++; $display("[TB] FAIL resid_rand: got %h expected 0A0908070", bus.randombits_o); end
    checks++; if (bus.level_o !== 3'd1) begin errors++; $display("[TB] FAIL resid_level: got %0d expected 1", bus.level_o); end
  endtask

  task automatic test_backpressure();
    int accepted;
    $display("[TB] test_backpressure");
    doReset();
    accepted        = 0;
    bus.rng_word_i  = 32'hAAAAAAAA;
    bus.rng_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (bus.rng_ready_o) accepted++;
      tick();
    end
    #1;
    checks++; if (accepted !== 7) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected 7", accepted); end
    checks++; if (bus.level_o !== 3'd4) begin errors++; $display("[TB] FAIL bp_level_full: got %0d expected 4", bus.level_o); end
    checks++; if (bus.rng_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b expected 0", bus.rng_ready_o); end
    checks++; if (bus.shareB_o !== 8'hAA) begin errors++; $display("[TB] FAIL bp_shareB: got %h expected AA", bus.shareB_o); end
    checks++; if (bus.randombits_o !== 36'hAAAAAAAAA) begin errors++; $display("[TB] FAIL bp_rand: got %h expected AAAAAAAAA", bus.randombits_o); end
    bus.rng_valid_i = 1'b0;
    bus.consume_i   = 1'b1;
    tick();
    bus.consume_i = 1'b0;
    #1;
    checks++; if (bus.level_o !== 3'd3) begin errors++; $display("[TB] FAIL bp_level_pop: got %0d expected 3", bus.level_o); end
    checks++; if (bus.rng_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_push: got %b expected 1", bus.rng_ready_o); end
    tick();
    checks++; if (bus.level_o !== 3'd4) begin errors++; $display("[TB] FAIL bp_level_refill: got %0d expected 4", bus.level_o); end
  endtask

  task automatic test_back_to_back();
    int wordsSent;
    int pops;
    $display("[TB] test_back_to_back");
    doReset();
    wordsSent      = 0;
    pops           = 0;
    bus.consume_i  = 1'b1;
    bus.rng_word_i = 32'hFFFFFFFF;
    for (int c = 0; c < 40; c++) begin
      bus.rng_valid_i = (wordsSent < 11);
      #1;
      if (bus.rng_valid_i && bus.rng_ready_o) wordsSent++;
      if (bus.rand_valid_o) begin
        pops++;
        checks++;
        if (bus.shareB_o !== 8'hFF || bus.randombits_o !== 36'hFFFFFFFFF) begin
          errors++;
          $display("[TB] FAIL b2b_bundle: got %h/%h expected FF/FFFFFFFFF", bus.shareB_o, bus.randombits_o);
        end
      end
      tick();
    end
    bus.rng_valid_i = 1'b0;
    bus.consume_i   = 1'b0;
    #1;
    checks++; if (wordsSent !== 11) begin errors++; $display("[TB] FAIL b2b_words: got %0d expected 11", wordsSent); end
    checks++; if (pops !== 8) begin errors++; $display("[TB] FAIL b2b_pops: got %0d expected 8", pops); end
    checks++; if (bus.level_o !== 3'd0) begin errors++; $display("[TB] FAIL b2b_level: got %0d expected 0", bus.level_o); end
    // An empty accumulator means the next bundle starts exactly at the next word.
    pushWord(32'h12345678);
    pushWord(32'h9ABCDEF0);
    tick();
    checks++; if (bus.shareB_o !== 8'h78) begin errors++; $display("[TB] FAIL b2b_fill_shareB: got %h expected 78", bus.shareB_o); end
    checks++; if (bus.randombits_o !== 36'hEF0123456) begin errors++; $display("[TB] FAIL b2b_fill_rand: got %h expected EF0123456", bus.randombits_o); end
  endtask

  task automatic test_starve();
    $display("[TB] test_starve");
    doReset();
    bus.consume_i = 1'b1;
    tick();
    bus.consume_i = 1'b0;
    #1;
    checks++; if (bus.starve_o !== 1'b1) begin errors++; $display("[TB] FAIL starve_set: got %b expected 1", bus.starve_o); end
    checks++; if (bus.rand_valid_o !== 1'b0 || bus.shareB_o !== 8'h00 || bus.randombits_o !== 36'h0) begin
      errors++; $display("[TB] FAIL starve_outputs: got %b/%h/%h expected 0/00/0", bus.rand_valid_o, bus.shareB_o, bus.randombits_o);
    end
    checks++; if (bus.level_o !== 3'd0) begin errors++; $display("[TB] FAIL starve_level: got %0d expected 0", bus.level_o); end
    tick();
    checks++; if (bus.starve_o !== 1'b1) begin errors++; $display("[TB] FAIL starve_sticky: got %b expected 1", bus.starve_o); end
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.rng_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL starve_flush_ready: got %b expected 0", bus.rng_ready_o); end
    tick();
    bus.flush_i = 1'b0;
    #1;
    checks++; if (bus.starve_o !== 1'b0) begin errors++; $display("[TB] FAIL starve_clear: got %b expected 0", bus.starve_o); end
  endtask

  task automatic test_flush();
    $display("[TB] test_flush");
    doReset();
    for (int i = 0; i < 5; i++) pushWord(32'h55555555);
    tick();
    checks++; if (bus.level_o !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_level: got %0d expected 3", bus.level_o); end
    bus.flush_i     = 1'b1;
    bus.rng_valid_i = 1'b1;
    bus.rng_word_i  = 32'hDEADBEEF;
    bus.consume_i   = 1'b1;
    #1;
    checks++; if (bus.rng_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 0", bus.rng_ready_o); end
    tick();
    bus.flush_i     = 1'b0;
    bus.rng_valid_i = 1'b0;
    bus.consume_i   = 1'b0;
    #1;
    checks++; if (bus.level_o !== 3'd0) begin errors++; $display("[TB] FAIL flush_level: got %0d expected 0", bus.level_o); end
    checks++; if (bus.rand_valid_o !== 1'b0 || bus.shareB_o !== 8'h00 || bus.randombits_o !== 36'h0) begin
      errors++; $display("[TB] FAIL flush_outputs: got %b/%h/%h expected 0/00/0", bus.rand_valid_o, bus.shareB_o, bus.randombits_o);
    end
    pushWord(32'h11111111);
    pushWord(32'h22222222);
    tick();
    checks++; if (bus.shareB_o !== 8'h11) begin errors++; $display("[TB] FAIL flush_post_shareB: got %h expected 11", bus.shareB_o); end
    checks++; if (bus.randombits_o !== 36'h222111111) begin errors++; $display("[TB] FAIL flush_post_rand: got %h expected 222111111", bus.randombits_o); end
    checks++; if (bus.level_o !== 3'd1) begin errors++; $display("[TB] FAIL flush_post_level: got %0d expected 1", bus.level_o); end
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    doReset();
    bus.rng_word_i  = 32'hDEADBEEF;
    bus.rng_valid_i = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (bus.rand_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_valid: got %b expected 1", bus.rand_valid_o); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.rand_valid_o !== 1'b0 || bus.shareB_o !== 8'h00 || bus.randombits_o !== 36'h0) begin
      errors++; $display("[TB] FAIL arst_outputs: got %b/%h/%h expected 0/00/0", bus.rand_valid_o, bus.shareB_o, bus.randombits_o);
    end
    checks++; if (bus.level_o !== 3'd0) begin errors++; $display("[TB] FAIL arst_level: got %0d expected 0", bus.level_o); end
    bus.rng_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    pushWord(32'h44444444);
    pushWord(32'h33333333);
    tick();
    checks++; if (bus.shareB_o !== 8'h44) begin errors++; $display("[TB] FAIL arst_post_shareB: got %h expected 44", bus.shareB_o); end
    checks++; if (bus.randombits_o !== 36'h333444444) begin errors++; $display("[TB] FAIL arst_post_rand: got %h expected 333444444", bus.randombits_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_packing();
    test_backpressure();
    test_back_to_back();
    test_starve();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
